// File: rtl/seg_scan_capture.sv
// seg_scan_capture: read-back monitor for a multiplexed seven-segment bus.
// Waits for each {anode, segment} bus value to hold for STABLE_CYCLES edges,
// then decodes it into the 4-bit slot of the single active anode position.
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   seg_in        - segment lines abcdefg, active-low, bit 6 = a
//   an_in         - anode lines, active-low, bit i = position i
//   clr_err       - synchronous clear of the sticky error flags
//   digits_out    - captured code per position, position i at [4i+3:4i]
//   digit_seen    - positions captured since the last frame boundary
//   frame_valid   - one-cycle pulse after every position has been captured
//   err_pattern   - sticky: undecodable segment pattern captured
//   err_anode     - sticky: stable bus value with more than one anode active
module seg_scan_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    clr_err,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_seen,
    output logic                    frame_valid,
    output logic                    err_pattern,
    output logic                    err_anode
);

    localparam int unsigned SW = NUM_DIGITS + 7;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 2);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES);

    logic [SW-1:0]         sample_reg;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt_c;
    logic [SW-1:0]         live_c;
    logic [NUM_DIGITS-1:0] s_an_c;
    logic [6:0]            s_seg_c;
    logic [3:0]            code_c;
    logic                  bad_c;
    logic [3:0]            low_cnt_c;
    logic [IW-1:0]         pos_c;
    logic                  capture_c;
    logic                  wr_c;
    logic                  pat_err_c;
    logic                  anode_err_c;
    logic                  full_c;
    logic [NUM_DIGITS-1:0] seen_nxt_c;

    assign live_c  = {an_in, seg_in};
    assign s_an_c  = sample_reg[SW-1:7];
    assign s_seg_c = sample_reg[6:0];

    // Stability counter: restarts at 1 on any change, saturates one past the
    // capture value so a held bus captures exactly once.
    always_comb begin
        cnt_nxt_c = CW'(1);
        if (live_c == sample_reg) begin
            cnt_nxt_c = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        end
    end

    assign capture_c = (cnt == CNT_CAP);

    // Segment decode (active-low abcdefg)
    always_comb begin
        code_c = 4'hE;
        bad_c  = 1'b0;
        case (s_seg_c)
            7'b0000001: code_c = 4'h0;
            7'b1001111: code_c = 4'h1;
            7'b0010010: code_c = 4'h2;
            7'b0000110: code_c = 4'h3;
            7'b1001100: code_c = 4'h4;
            7'b0100100: code_c = 4'h5;
            7'b0100000: code_c = 4'h6;
            7'b0001111: code_c = 4'h7;
            7'b0000000: code_c = 4'h8;
            7'b0000100: code_c = 4'h9;
            7'b1111111: code_c = 4'hF;
            default: begin
                code_c = 4'hE;
                bad_c  = 1'b1;
            end
        endcase
    end

    // Count active anodes; pos_c is only meaningful when exactly one is low
    always_comb begin
        low_cnt_c = 4'd0;
        pos_c     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an_c[i]) begin
                low_cnt_c = low_cnt_c + 4'd1;
                pos_c     = IW'(i);
            end
        end
    end

    assign wr_c        = capture_c && (low_cnt_c == 4'd1);
    assign pat_err_c   = wr_c && bad_c;
    assign anode_err_c = capture_c && (low_cnt_c > 4'd1);
    assign full_c      = &digit_seen;

    // A completed frame clears the seen mask one edge after it fills
    always_comb begin
        seen_nxt_c = full_c ? '0 : digit_seen;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_c && (pos_c == IW'(i))) begin
                seen_nxt_c[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg  <= '1;
            cnt         <= '0;
            digits_out  <= '1;
            digit_seen  <= '0;
            frame_valid <= 1'b0;
            err_pattern <= 1'b0;
            err_anode   <= 1'b0;
        end else begin
            sample_reg  <= live_c;
            cnt         <= cnt_nxt_c;
            digit_seen  <= seen_nxt_c;
            frame_valid <= full_c;
            // New error on the clearing edge wins
            err_pattern <= (err_pattern && !clr_err) || pat_err_c;
            err_anode   <= (err_anode && !clr_err) || anode_err_c;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_c && (pos_c == IW'(i))) begin
                    digits_out[4*i +: 4] <= code_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg_scan_capture;

    localparam int unsigned N = 4;
    localparam int unsigned S = 4;
    localparam logic [3:0] IDLE_AN = 4'b1111;
    localparam logic [6:0] BLANK   = 7'b1111111;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   seg_in;
    logic [N-1:0] an_in;
    logic         clr_err;
    logic [4*N-1:0] digits_out;
    logic [N-1:0] digit_seen;
    logic         frame_valid;
    logic         err_pattern;
    logic         err_anode;

    seg_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .clr_err     (clr_err),
        .digits_out  (digits_out),
        .digit_seen  (digit_seen),
        .frame_valid (frame_valid),
        .err_pattern (err_pattern),
        .err_anode   (err_anode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;

    // Reference model state
    logic [3:0] m_dig [N];
    logic [N-1:0] m_seen;
    logic m_perr, m_aerr;
    int   m_frames = 0;
    logic [10:0] last_val;

    logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100};

    always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_dig[i] = 4'hF;
        m_seen = '0;
        m_perr = 1'b0;
        m_aerr = 1'b0;
    endtask

    // Effect of one captured bus value
    task automatic model_apply(input logic [3:0] an, input logic [6:0] sg);
        int zeros;
        int p;
        logic [3:0] code;
        logic bad;
        zeros = 0;
        p = 0;
        for (int i = 0; i < N; i++) if (!an[i]) begin zeros++; p = i; end
        if (zeros == 1) begin
            bad = 1'b0;
            code = 4'hE;
            if (sg == BLANK) code = 4'hF;
            else begin
                bad = 1'b1;
                for (int d = 0; d < 10; d++) if (pats[d] == sg) begin code = 4'(d); bad = 1'b0; end
            end
            m_dig[p] = code;
            if (bad) m_perr = 1'b1;
            m_seen[p] = 1'b1;
            if (m_seen == '1) begin
                m_frames++;
                m_seen = '0;
            end
        end else if (zeros > 1) begin
            m_aerr = 1'b1;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
        an_in = an;
        seg_in = sg;
        last_val = {an, sg};
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a value; it is captured by the DUT when held at least S edges
    task automatic step(input logic [3:0] an, input logic [6:0] sg, input int n);
        drive(an, sg, n);
        if (n >= S) model_apply(an, sg);
    endtask

    task automatic idle();
        drive(IDLE_AN, BLANK, 8);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        drive(IDLE_AN, BLANK, 1);
        clr_err = 1'b0;
        m_perr = 1'b0;
        m_aerr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [4*N-1:0] exp_d;
        for (int i = 0; i < N; i++) exp_d[4*i +: 4] = m_dig[i];
        check({tag, ".digits"}, 32'(digits_out), 32'(exp_d));
        check({tag, ".seen"}, 32'(digit_seen), 32'(m_seen));
        check({tag, ".err_pattern"}, 32'(err_pattern), 32'(m_perr));
        check({tag, ".err_anode"}, 32'(err_anode), 32'(m_aerr));
        check({tag, ".frames"}, 32'(fv_count), 32'(m_frames));
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] sg;
        int n;
        int p;
        rst = 1'b1;
        clr_err = 1'b0;
        an_in = IDLE_AN;
        seg_in = BLANK;
        last_val = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.frame_valid", 32'(frame_valid), 32'd0);
        rst = 1'b0;

        // Full frame 1234 with frame pulse timing
        step(4'b0111, 7'b1001111, 8);
        step(4'b1011, 7'b0010010, 8);
        step(4'b1101, 7'b0000110, 8);
        drive(4'b1110, 7'b1001100, S + 1);
        check("frame.capture_seen", 32'(digit_seen), 32'hF);
        check("frame.capture_digits", 32'(digits_out), 32'h1234);
        check("frame.capture_fv", 32'(frame_valid), 32'd0);
        @(posedge clk); #1;
        check("frame.pulse_fv", 32'(frame_valid), 32'd1);
        check("frame.pulse_seen", 32'(digit_seen), 32'd0);
        check("frame.pulse_digits", 32'(digits_out), 32'h1234);
        @(posedge clk); #1;
        check("frame.after_fv", 32'(frame_valid), 32'd0);
        model_apply(4'b1110, 7'b1001100);
        idle();
        check_all("frame");

        // Glitch rejection at exactly S-1 and S edges
        step(4'b1110, 7'b0000000, S - 1);
        idle();
        check("glitch.short", 32'(digits_out), 32'h1234);
        step(4'b1110, 7'b0000000, S);
        idle();
        check("glitch.exact", 32'(digits_out), 32'h1238);
        check_all("glitch");

        // Bad pattern, persistence, clear, clear colliding with new error
        step(4'b1011, 7'b1010101, 8);
        idle();
        check("badpat.slot2", 32'(digits_out[11:8]), 32'hE);
        check("badpat.flag", 32'(err_pattern), 32'd1);
        step(4'b0111, 7'b0000001, 8);
        step(4'b1011, 7'b1001111, 8);
        step(4'b1101, 7'b0010010, 8);
        step(4'b1110, 7'b0000110, 8);
        idle();
        check("badpat.sticky", 32'(err_pattern), 32'd1);
        check_all("badpat");
        pulse_clr();
        check("badpat.cleared", 32'(err_pattern), 32'd0);
        drive(4'b1011, 7'b1010101, S);
        clr_err = 1'b1;
        drive(IDLE_AN, BLANK, 1);
        clr_err = 1'b0;
        m_perr = 1'b0;
        m_aerr = 1'b0;
        model_apply(4'b1011, 7'b1010101);
        check("badpat.clr_collide", 32'(err_pattern), 32'd1);
        idle();
        pulse_clr();
        check_all("clr");

        // Anode faults
        step(4'b1100, 7'b0000000, 8);
        idle();
        check("anode.multi", 32'(err_anode), 32'd1);
        check_all("anode.multi");
        pulse_clr();
        step(4'b1111, 7'b0000000, 8);
        idle();
        check("anode.none", 32'(err_anode), 32'd0);
        check_all("anode.none");

        // Partial frame with errors, then asynchronous reset mid-run
        step(4'b1100, 7'b0000000, 8);
        step(4'b1110, 7'b1010101, 8);
        drive(4'b1101, 7'b0000001, 2);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("midreset");
        check("midreset.fv", 32'(frame_valid), 32'd0);
        an_in = IDLE_AN;
        seg_in = BLANK;
        last_val = '1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Re-capture before frame completion
        step(4'b1110, 7'b0100100, 8);
        step(4'b1110, 7'b0001111, 8);
        idle();
        check("recap.slot0", 32'(digits_out[3:0]), 32'h7);
        check("recap.seen", 32'(digit_seen), 32'b0001);
        check_all("recap.partial");
        p = fv_count;
        step(4'b1101, 7'b0000001, 8);
        step(4'b1011, 7'b0000001, 8);
        idle();
        check("recap.no_frame_yet", 32'(fv_count), 32'(p));
        step(4'b0111, 7'b0000001, 8);
        idle();
        check("recap.frame", 32'(fv_count), 32'(p + 1));
        check_all("recap.done");

        // Randomized scan against the model
        for (int k = 0; k < 80; k++) begin
            do begin
                p = $urandom_range(0, N - 1);
                an = ~(4'b0001 << p);
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: sg = pats[$urandom_range(0, 9)];
                    6: sg = BLANK;
                    7: sg = 7'($urandom);
                    8: begin an = 4'($urandom); sg = pats[$urandom_range(0, 9)]; end
                    default: begin an = IDLE_AN; sg = 7'($urandom); end
                endcase
            end while ({an, sg} == last_val);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S - 1) : $urandom_range(S, S + 4);
            step(an, sg, n);
            if ((k % 8) == 7) begin
                idle();
                check_all("random");
                if ($urandom_range(0, 1) == 1) pulse_clr();
            end
        end
        idle();
        check_all("random.end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
